// File: rtl/qmn_addsub_pipe.sv
// Two-stage signed Qm.n adder/subtractor with valid/ready flow control,
// optional saturation and a saturating count of delivered overflow beats.
module qmn_addsub_pipe #(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8,
  parameter bit SATURATE  = 1'b1,
  parameter int CNT_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] operand1,
  input  logic [INT_BITS+FRAC_BITS-1:0] operand2,
  input  logic                          add_sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] result,
  output logic                          overflow,
  output logic [CNT_BITS-1:0]           ovf_count
);

  localparam int W = INT_BITS + FRAC_BITS;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic         s1_sub;

  logic         advance;
  logic         accept;
  logic         deliver;

  logic [W:0]   a_x;
  logic [W:0]   b_x;
  logic [W:0]   sum;
  logic         ovf;
  logic [W-1:0] res_c;

  assign advance = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // One guard bit makes the sum exact; overflow shows as guard != MSB.
  always_comb begin
    a_x = {s1_a[W-1], s1_a};
    b_x = {s1_b[W-1], s1_b};
    sum = s1_sub ? (a_x - b_x) : (a_x + b_x);
    ovf = sum[W] ^ sum[W-1];
    res_c = sum[W-1:0];
    if (ovf && SATURATE) begin
      res_c = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sub   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= operand1;
      s1_b     <= operand2;
      s1_sub   <= add_sub;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= res_c;
        overflow <= ovf;
      end
    end
  end

  // Counts only beats the consumer actually took, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (deliver && overflow && (ovf_count != {CNT_BITS{1'b1}})) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_qmn_addsub_pipe.sv
// Bench for qmn_addsub_pipe: saturating, wrapping and 2-bit-counter variants
// share one stimulus stream and are scored against an integer reference model.
module tb_qmn_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic        add_sub;

  logic        in_ready,  out_valid,  overflow;
  logic [15:0] result;
  logic [7:0]  ovf_count;
  logic        in_ready_w, out_valid_w, overflow_w;
  logic [15:0] result_w;
  logic [7:0]  ovf_count_w;
  logic        in_ready_c, out_valid_c, overflow_c;
  logic [15:0] result_c;
  logic [1:0]  ovf_count_c;

  qmn_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .add_sub(add_sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .ovf_count(ovf_count)
  );

  qmn_addsub_pipe #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .operand1(operand1), .operand2(operand2), .add_sub(add_sub),
    .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
    .overflow(overflow_w), .ovf_count(ovf_count_w)
  );

  qmn_addsub_pipe #(.CNT_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .operand1(operand1), .operand2(operand2), .add_sub(add_sub),
    .out_valid(out_valid_c), .out_ready(out_ready), .result(result_c),
    .overflow(overflow_c), .ovf_count(ovf_count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] q_s[$];
  logic [15:0] q_w[$];
  logic        q_o[$];
  int          m_cnt8;
  int          m_cnt2;

  logic [15:0] cur_es, cur_ew;
  logic        cur_eo;
  logic        last_acc;
  logic        last_in_ready;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                    output logic [15:0] es, output logic [15:0] ew,
                                    output logic eo);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sub ? (sa - sb) : (sa + sb);
    eo = (s > 32767) || (s < -32768);
    ew = s[15:0];
    es = !eo ? s[15:0] : ((s > 0) ? 16'h7FFF : 16'h8000);
  endfunction

  // One clock: score outputs before the edge, book handshakes, then check counters after it.
  task automatic cycle();
    logic acc, del;
    @(negedge clk);
    if (!rst) begin
      if (out_valid && q_s.size() == 0) begin
        chk("spurious_out_valid", 16'(out_valid), 16'd0);
      end else if (out_valid) begin
        chk("result_sat", result, q_s[0]);
        chk("overflow_sat", 16'(overflow), 16'(q_o[0]));
        chk("out_valid_wrap", 16'(out_valid_w), 16'd1);
        chk("result_wrap", result_w, q_w[0]);
        chk("overflow_wrap", 16'(overflow_w), 16'(q_o[0]));
        chk("result_cnt2", result_c, q_s[0]);
        chk("overflow_cnt2", 16'(overflow_c), 16'(q_o[0]));
      end
      chk("in_ready_variants", 16'({in_ready_w, in_ready_c}), 16'({in_ready, in_ready}));
    end
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    last_in_ready = in_ready;
    if (rst) begin
      q_s.delete();
      q_w.delete();
      q_o.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
      acc = 1'b0;
    end else begin
      if (del && q_s.size() != 0) begin
        if (q_o[0]) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        void'(q_s.pop_front());
        void'(q_w.pop_front());
        void'(q_o.pop_front());
      end
      if (acc) begin
        q_s.push_back(cur_es);
        q_w.push_back(cur_ew);
        q_o.push_back(cur_eo);
      end
    end
    @(posedge clk);
    #1;
    chk("ovf_count", 16'(ovf_count), 16'(m_cnt8));
    chk("ovf_count_cnt2", 16'(ovf_count_c), 16'(m_cnt2));
    last_acc = acc;
  endtask

  task automatic push_beat(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [15:0] es, input logic [15:0] ew, input logic eo);
    operand1 = a;
    operand2 = b;
    add_sub  = sub;
    cur_es   = es;
    cur_ew   = ew;
    cur_eo   = eo;
    in_valid = 1'b1;
    last_acc = 1'b0;
    for (int k = 0; k < 20 && !last_acc; k++) cycle();
    in_valid = 1'b0;
    if (!last_acc) chk("accept_timeout", 16'(last_acc), 16'd1);
  endtask

  task automatic push_rand(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [15:0] es, ew;
    logic        eo;
    ref_model(a, b, sub, es, ew, eo);
    push_beat(a, b, sub, es, ew, eo);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && q_s.size() != 0; k++) cycle();
    chk("drain_empty", 16'(q_s.size()), 16'd0);
  endtask

  initial begin
    int idx, accepted, r;
    logic saw_block;
    logic [15:0] a, b;
    logic [15:0] es, ew;
    logic        eo;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operand1 = '0; operand2 = '0; add_sub = 1'b0;
    cur_es = '0; cur_ew = '0; cur_eo = 1'b0;
    last_acc = 1'b0; last_in_ready = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0;
    cycle();
    cycle();
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_ovf_count", 16'(ovf_count), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    rst = 1'b0;

    // Latency: accept edge, one cycle in S1, valid on the following cycle.
    out_ready = 1'b1;
    push_beat(16'h0100, 16'h0080, 1'b0, 16'h0180, 16'h0180, 1'b0);
    chk("lat_t1_out_valid", 16'(out_valid), 16'd0);
    cycle();
    chk("lat_t2_out_valid", 16'(out_valid), 16'd1);
    chk("lat_t2_result", result, 16'h0180);
    drain();

    push_beat(16'h0080, 16'h0100, 1'b1, 16'hFF80, 16'hFF80, 1'b0);
    push_beat(16'h0001, 16'h0100, 1'b1, 16'hFF01, 16'hFF01, 1'b0);
    push_beat(16'h7F00, 16'h0200, 1'b0, 16'h7FFF, 16'h8100, 1'b1);
    push_beat(16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
    push_beat(16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0);
    push_beat(16'h0000, 16'h8000, 1'b1, 16'h7FFF, 16'h8000, 1'b1);
    push_beat(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'hFFFE, 1'b1);
    drain();
    chk("edge_ovf_count", 16'(ovf_count), 16'd4);

    // Backpressure: six beats, consumer stalls for four cycles mid-stream.
    idx = 0;
    saw_block = 1'b0;
    for (int k = 0; k < 40 && (idx < 6 || q_s.size() != 0); k++) begin
      out_ready = !(k >= 3 && k < 7);
      in_valid  = (idx < 6);
      operand1  = 16'(16'h1000 + idx * 16'h0123);
      operand2  = 16'(16'h0040 * idx);
      add_sub   = idx[0];
      ref_model(operand1, operand2, add_sub, es, ew, eo);
      cur_es = es; cur_ew = ew; cur_eo = eo;
      cycle();
      if (in_valid && !last_in_ready) saw_block = 1'b1;
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_in_ready_dropped", 16'(saw_block), 16'd1);
    chk("bp_all_accepted", 16'(idx), 16'd6);
    chk("bp_all_delivered", 16'(q_s.size()), 16'd0);

    // Reset with two beats in flight: nothing may emerge afterwards.
    out_ready = 1'b0;
    push_beat(16'h7F00, 16'h0200, 1'b0, 16'h7FFF, 16'h8100, 1'b1);
    push_beat(16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
    chk("mid_pipe_full", 16'(out_valid), 16'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_ovf_count", 16'(ovf_count), 16'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("mid_rst_no_output", 16'(out_valid), 16'd0);

    // 2-bit counter: a stalled overflow beat is not counted until taken.
    out_ready = 1'b0;
    push_rand(16'h7F00, 16'h0200, 1'b0);
    for (int k = 0; k < 3; k++) cycle();
    chk("cnt_stalled_not_counted", 16'(ovf_count_c), 16'd0);
    out_ready = 1'b1;
    push_rand(16'h8000, 16'h0100, 1'b1);
    push_rand(16'h7000, 16'h7000, 1'b0);
    push_rand(16'h9000, 16'h9000, 1'b0);
    push_rand(16'h0000, 16'h8000, 1'b1);
    drain();
    chk("cnt2_saturated", 16'(ovf_count_c), 16'd3);
    chk("cnt8_five", 16'(ovf_count), 16'd5);

    // Random valid/ready traffic against the reference model.
    accepted = 0;
    for (int k = 0; k < 60000 && accepted < 10000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (last_acc || k == 0) begin
        r = $urandom_range(0, 3);
        a = 16'($urandom());
        b = 16'($urandom());
        if (r == 1) begin a = {8'h7F, a[7:0]}; b = {1'b0, b[14:0]}; end
        if (r == 2) begin a = {8'h80, a[7:0]}; b = {1'b0, b[14:0]}; end
        if (r == 3) begin a = 16'($signed(a[9:0])); b = 16'($signed(b[9:0])); end
        operand1 = a;
        operand2 = b;
        add_sub  = 1'($urandom_range(0, 1));
        ref_model(operand1, operand2, add_sub, es, ew, eo);
        cur_es = es; cur_ew = ew; cur_eo = eo;
      end
      cycle();
      if (last_acc) accepted++;
    end
    in_valid = 1'b0;
    chk("rand_accepted", 16'(accepted), 16'(10000));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
